// File: rtl/mult_booth_seq.sv
`default_nettype none
// ============================================================================
//  Module      : mult_booth_seq
//  Description : Sequential radix-2 Booth multiplier for the RV32M multiply
//                group (MUL, MULH, MULHSU, MULHU). Operands are extended to
//                WIDTH+1 bits so all three signedness combinations share one
//                signed datapath. One Booth step is taken per RUN cycle,
//                giving WIDTH+1 steps per operation. An optional early-out
//                finishes in one cycle when either operand is zero.
//
//  Ports       : clk      - clock, rising edge active
//                reset    - asynchronous reset, active low
//                start    - begin a multiply (accepted in IDLE/DONE only)
//                funct3   - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU
//                rs1      - multiplicand
//                rs2      - multiplier
//                busy     - operation in progress
//                done     - one-cycle pulse, result valid
//                rd       - selected result half
//                product  - low 2*WIDTH bits of the full product
//
//  Revision    : 1.0 - initial release
// ============================================================================
module mult_booth_seq #(
    parameter int WIDTH     = 32,
    parameter int EARLY_OUT = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [2:0]           funct3,
    input  logic [WIDTH-1:0]     rs1,
    input  logic [WIDTH-1:0]     rs2,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     rd,
    output logic [2*WIDTH-1:0]   product
);

    localparam int c_CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    state_t                 state_q,   state_d;
    logic [c_CNT_W-1:0]     cnt_q,     cnt_d;
    logic [WIDTH+1:0]       acc_q,     acc_d;     // signed accumulator
    logic [WIDTH:0]         q_q,       q_d;       // extended multiplier
    logic                   qm1_q,     qm1_d;     // Booth guard bit
    logic [WIDTH:0]         mcand_q,   mcand_d;   // extended multiplicand
    logic [1:0]             op_q,      op_d;      // captured funct3[1:0]
    logic                   busy_q,    busy_d;
    logic                   done_q,    done_d;
    logic [WIDTH-1:0]       rd_q,      rd_d;
    logic [2*WIDTH-1:0]     product_q, product_d;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic                   w_accept;
    logic                   w_zero;
    logic [WIDTH:0]         w_rs1_ext;
    logic [WIDTH:0]         w_rs2_ext;
    logic [WIDTH+1:0]       w_mext;
    logic [WIDTH+1:0]       w_addend;
    logic [WIDTH+1:0]       w_sum;
    logic [WIDTH+1:0]       w_acc_shift;
    logic [WIDTH:0]         w_q_shift;
    logic [2*WIDTH-1:0]     w_prod;

    always_comb begin
        // funct3[2] set means a divide-group op: not ours, ignore the start.
        w_accept = start && !funct3[2] && ((state_q == IDLE) || (state_q == DONE));
        w_zero   = (EARLY_OUT != 0) && ((rs1 == '0) || (rs2 == '0));

        // rs1 is unsigned only for MULHU; rs2 is unsigned for MULHSU/MULHU.
        w_rs1_ext = {(funct3[1:0] != 2'b11) & rs1[WIDTH-1], rs1};
        w_rs2_ext = {!funct3[1] & rs2[WIDTH-1], rs2};

        // Multiplicand sign-extended to the accumulator width. The extra
        // accumulator bit keeps -(-2^WIDTH) representable.
        w_mext = {mcand_q[WIDTH], mcand_q};

        unique case ({q_q[0], qm1_q})
            2'b01:   w_addend = w_mext;
            2'b10:   w_addend = -w_mext;
            default: w_addend = '0;
        endcase

        w_sum       = acc_q + w_addend;
        w_acc_shift = {w_sum[WIDTH+1], w_sum[WIDTH+1:1]};
        w_q_shift   = {w_sum[0], q_q[WIDTH:1]};

        // {acc,q} holds the sign-extended 2*WIDTH+2 bit product after the
        // last step; only its low 2*WIDTH bits are reported.
        w_prod      = {w_acc_shift[WIDTH-2:0], w_q_shift};
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        q_d       = q_q;
        qm1_d     = qm1_q;
        mcand_d   = mcand_q;
        op_d      = op_q;
        rd_d      = rd_q;
        product_d = product_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (w_accept) begin
                    op_d    = funct3[1:0];
                    mcand_d = w_rs1_ext;
                    q_d     = w_rs2_ext;
                    qm1_d   = 1'b0;
                    acc_d   = '0;
                    cnt_d   = '0;
                    if (w_zero) begin
                        state_d   = DONE;
                        product_d = '0;
                        rd_d      = '0;
                    end else begin
                        state_d   = RUN;
                    end
                end else begin
                    state_d = IDLE;
                end
            end

            RUN: begin
                acc_d = w_acc_shift;
                q_d   = w_q_shift;
                qm1_d = q_q[0];
                if (cnt_q == c_CNT_W'(WIDTH)) begin
                    state_d   = DONE;
                    product_d = w_prod;
                    rd_d      = (op_q == 2'b00) ? w_prod[WIDTH-1:0]
                                                : w_prod[2*WIDTH-1:WIDTH];
                end else begin
                    cnt_d = cnt_q + c_CNT_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Status outputs are registered copies of the next state.
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            q_q       <= '0;
            qm1_q     <= 1'b0;
            mcand_q   <= '0;
            op_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rd_q      <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            q_q       <= q_d;
            qm1_q     <= qm1_d;
            mcand_q   <= mcand_d;
            op_q      <= op_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            rd_q      <= rd_d;
            product_q <= product_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign rd      = rd_q;
    assign product = product_q;

endmodule
`default_nettype wire

// File: doc/mult_booth_seq.md
MULT_BOOTH_SEQ -- requirements
Module: mult_booth_seq

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, operand width in bits (legal: even, 8..64).
REQ-002 The module SHALL have parameter EARLY_OUT, default 1, which enables a zero-operand short cut when 1.
REQ-003 The module SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port reset, input, 1 bit, asynchronous active-low reset.
REQ-005 The module SHALL have port start, input, 1 bit, request to begin a multiply.
REQ-006 The module SHALL have port funct3, input, 3 bits, RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU.
REQ-007 The module SHALL have port rs1, input, WIDTH bits, multiplicand.
REQ-008 The module SHALL have port rs2, input, WIDTH bits, multiplier.
REQ-009 The module SHALL have port busy, output, 1 bit, high while an operation is in progress.
REQ-010 The module SHALL have port done, output, 1 bit, one-cycle pulse when the result is valid.
REQ-011 The module SHALL have port rd, output, WIDTH bits, selected result half.
REQ-012 The module SHALL have port product, output, 2*WIDTH bits, full product.

Function
REQ-013 The FSM SHALL have states IDLE, RUN and DONE; in IDLE busy=0 and done=0; in RUN busy=1 and done=0; in DONE busy=0 and done=1.
REQ-014 A start SHALL be accepted only in IDLE or DONE and only when funct3[2]=0; otherwise the start SHALL be ignored with no state change.
REQ-015 On accept, the block SHALL capture rs1, rs2 and funct3 into internal registers; input changes after the accept edge SHALL have no effect.
REQ-016 Operand extension SHALL be to WIDTH+1 bits: rs1 sign-extended for MUL, MULH and MULHSU and zero-extended for MULHU; rs2 sign-extended for MUL and MULH and zero-extended for MULHSU and MULHU.
REQ-017 The datapath SHALL be radix-2 Booth with a (WIDTH+2)-bit signed accumulator, the extended multiplier and a Booth guard bit.
REQ-018 Each RUN cycle SHALL do one step on {q0,q-1}: 01 add the multiplicand; 10 subtract it; 00 or 11 no add; then arithmetic-shift {acc,q,q-1} right by 1.
REQ-019 An internal step counter SHALL reset to 0 on accept; after WIDTH+1 steps (counter = WIDTH) the FSM SHALL go RUN->DONE.
REQ-020 Latency SHALL be: start accepted at edge k, done high in the cycle after edge k+WIDTH+1.
REQ-021 product SHALL equal the low 2*WIDTH bits of the exact (WIDTH+1)x(WIDTH+1) signed product.
REQ-022 rd SHALL be product[WIDTH-1:0] for MUL and product[2*WIDTH-1:WIDTH] for MULH, MULHSU and MULHU.
REQ-023 When EARLY_OUT=1 and the captured rs1 or rs2 is zero, the FSM SHALL go directly to DONE at the accept edge with product=0, so done is high in the cycle after edge k.
REQ-024 DONE SHALL last exactly one cycle and then return to IDLE unless a new start is accepted, which allows back-to-back operation.
REQ-025 rd and product SHALL hold their last result through IDLE until the next DONE.
REQ-026 During RUN, rd and product SHALL keep the previous result; partial sums SHALL NOT be visible.

Reset
REQ-027 reset=0 SHALL asynchronously force state IDLE, counter 0, accumulator 0, busy=0, done=0, rd=0 and product=0.
REQ-028 A reset asserted during RUN SHALL abort the operation and no done SHALL follow.
REQ-029 After reset deassertion, a start on the first rising edge SHALL be accepted.

Verification
REQ-030 The bench SHALL cover, at WIDTH=32: MUL with rs1=7, rs2=0xFFFFFFFD -> rd=0xFFFFFFEB, done after 33 edges.
REQ-031 The bench SHALL cover: MULH with rs1=rs2=0x80000000 -> rd=0x40000000, product=0x40000000_00000000.
REQ-032 The bench SHALL cover: MULHU with rs1=rs2=0xFFFFFFFF -> rd=0xFFFFFFFE, product=0xFFFFFFFE_00000001; then MULHSU with the same operands -> rd=0xFFFFFFFF, product=0xFFFFFFFF_00000001.
REQ-033 The bench SHALL cover: EARLY_OUT=1, MUL with rs1=0, rs2=0x1234 -> done in the cycle after the accept edge, rd=0; and a start during RUN is ignored, so the first result is unchanged.
REQ-034 The bench SHALL cover: reset pulsed low at step 10 of a MULH -> busy=0, rd=0 immediately, no done; a following MULHU with 3x5 gives product=15.
REQ-035 The bench SHALL cover: start held high with funct3=100 -> busy stays 0 and done never asserts; a back-to-back start in DONE is accepted with no IDLE cycle.
